// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock,
// deframes 11-bit device frames and strobes out scan codes or errors.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_code_ready,
  output logic       scan_code_error
);

  localparam logic [7:0]  FLT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [15:0] WD_MAX  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0]  clk_s;
  logic [1:0]  dat_s;
  logic        fclk;
  logic [7:0]  fcnt;
  logic        fall;
  state_t      state;
  logic [7:0]  shift;
  logic [2:0]  idx;
  logic        par;
  logic [15:0] wd;
  logic        bit_s;

  assign bit_s = dat_s[1];

  // Idle bus is high, so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fclk <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else if (clk_s[1] == fclk) begin
      fcnt <= '0;
      fall <= 1'b0;
    end else if (fcnt == FLT_MAX) begin
      fclk <= clk_s[1];
      fcnt <= '0;
      fall <= ~clk_s[1];
    end else begin
      fcnt <= fcnt + 8'd1;
      fall <= 1'b0;
    end
  end

  // Timeout is checked before the fall strobe so it wins a tie.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      shift           <= '0;
      idx             <= '0;
      par             <= 1'b0;
      wd              <= '0;
      scan_code       <= '0;
      scan_code_ready <= 1'b0;
      scan_code_error <= 1'b0;
    end else begin
      scan_code_ready <= 1'b0;
      scan_code_error <= 1'b0;
      if (state != IDLE && wd == WD_MAX) begin
        scan_code_error <= 1'b1;
        state           <= IDLE;
        shift           <= '0;
        idx             <= '0;
        wd              <= '0;
      end else if (fall) begin
        wd <= '0;
        unique case (state)
          IDLE: begin
            if (!bit_s) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              scan_code_error <= 1'b1;
            end
          end
          DATA: begin
            shift <= {bit_s, shift[7:1]};
            if (idx == 3'd7) begin
              state <= PARITY;
            end else begin
              idx <= idx + 3'd1;
            end
          end
          PARITY: begin
            par   <= bit_s;
            state <= STOP;
          end
          STOP: begin
            if (bit_s && (^shift ^ par)) begin
              scan_code       <= shift;
              scan_code_ready <= 1'b1;
            end else begin
              scan_code_error <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        wd <= '0;
      end else begin
        wd <= wd + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: table of frames plus
// hand sequences for glitches, timeout and mid-frame reset.
module tb_ps2_keyboard_rx;

  localparam int FLT  = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 100;

  logic       clk;
  logic       nreset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] scan_code;
  logic       scan_code_ready;
  logic       scan_code_error;

  int checks = 0;
  int errs   = 0;
  int n_rdy  = 0;
  int n_err  = 0;
  logic prev_rdy = 1'b0;
  logic prev_err = 1'b0;

  ps2_keyboard_rx #(
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .ps2_clk        (ps2_clk),
    .ps2_dat        (ps2_dat),
    .scan_code      (scan_code),
    .scan_code_ready(scan_code_ready),
    .scan_code_error(scan_code_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse width and exclusivity of the strobes.
  always @(negedge clk) begin
    if (prev_rdy) begin
      checks++;
      if (scan_code_ready) begin
        errs++;
        $display("FAIL ready_width: ready=%b want 0", scan_code_ready);
      end
    end
    if (prev_err) begin
      checks++;
      if (scan_code_error) begin
        errs++;
        $display("FAIL error_width: error=%b want 0", scan_code_error);
      end
    end
    if (scan_code_ready) begin
      checks++;
      if (scan_code_error) begin
        errs++;
        $display("FAIL exclusive: ready=1 error=%b want 0", scan_code_error);
      end
    end
    if (scan_code_ready) n_rdy++;
    if (scan_code_error) n_err++;
    prev_rdy = scan_code_ready;
    prev_err = scan_code_error;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_ok,
                            input logic stop);
    logic p;
    p = ~^d;
    if (!par_ok) p = ~p;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_ok;
    logic       stop;
    int         gap;
    logic       glitch;
    int         exp_rdy;
    int         exp_err;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r0, e0, n;
    logic [7:0] e0_bits;
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 50, 1'b0, 1, 0, 8'h1C};
    vecs[1] = '{8'hF0, 1'b1, 1'b1, 50, 1'b0, 1, 0, 8'hF0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 0,  1'b0, 1, 0, 8'h1C};
    vecs[3] = '{8'hF0, 1'b1, 1'b1, 50, 1'b0, 1, 0, 8'hF0};
    vecs[4] = '{8'h1C, 1'b0, 1'b1, 50, 1'b0, 0, 1, 8'hF0};
    vecs[5] = '{8'h55, 1'b1, 1'b0, 50, 1'b1, 0, 1, 8'hF0};
    vecs[6] = '{8'h1C, 1'b1, 1'b1, 50, 1'b0, 1, 0, 8'h1C};

    nreset  = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(5);
    chk("rst_code", scan_code, 8'h00);
    chk("rst_ready", scan_code_ready, 0);
    chk("rst_error", scan_code_error, 0);
    nreset = 1'b1;
    cyc(20);

    foreach (vecs[i]) begin
      cyc(vecs[i].gap);
      if (vecs[i].glitch) begin
        r0 = n_rdy;
        e0 = n_err;
        for (int g = 0; g < 3; g++) begin
          ps2_clk = 1'b0;
          cyc(5);
          ps2_clk = 1'b1;
          cyc(30);
        end
        chk("glitch_ready", n_rdy - r0, 0);
        chk("glitch_error", n_err - e0, 0);
      end
      r0 = n_rdy;
      e0 = n_err;
      send_frame(vecs[i].data, vecs[i].par_ok, vecs[i].stop);
      ps2_dat = 1'b1;
      chk($sformatf("v%0d_ready", i), n_rdy - r0, vecs[i].exp_rdy);
      chk($sformatf("v%0d_error", i), n_err - e0, vecs[i].exp_err);
      chk($sformatf("v%0d_code", i), scan_code, vecs[i].exp_code);
    end

    // Timeout: start + 3 data bits of 0xE0, then clock parked high.
    // Error lands FLT+3+TMO edges after the last falling pin edge
    // (2 sync, FLT filter, 1 FSM, TMO watchdog).
    cyc(50);
    r0 = n_rdy;
    e0 = n_err;
    e0_bits = 8'hE0;
    send_bit(1'b0);
    send_bit(e0_bits[0]);
    send_bit(e0_bits[1]);
    ps2_dat = e0_bits[2];
    cyc(HALF);
    ps2_clk = 1'b0;
    n = 0;
    while (n < TMO + 200 && !scan_code_error) begin
      @(negedge clk);
      n++;
      if (n == HALF) ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    chk("tmo_latency", n, FLT + 3 + TMO);
    cyc(5);
    chk("tmo_error", n_err - e0, 1);
    chk("tmo_ready", n_rdy - r0, 0);
    chk("tmo_code", scan_code, 8'h1C);

    cyc(50);
    r0 = n_rdy;
    e0 = n_err;
    send_frame(8'hE0, 1'b1, 1'b1);
    ps2_dat = 1'b1;
    chk("e0_ready", n_rdy - r0, 1);
    chk("e0_error", n_err - e0, 0);
    chk("e0_code", scan_code, 8'hE0);

    // Reset after start + 4 data bits, then a clean 0x29 frame.
    cyc(50);
    r0 = n_rdy;
    e0 = n_err;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    cyc(20);
    nreset = 1'b0;
    cyc(3);
    chk("mid_rst_code", scan_code, 8'h00);
    nreset = 1'b1;
    cyc(50);
    send_frame(8'h29, 1'b1, 1'b1);
    ps2_dat = 1'b1;
    cyc(20);
    chk("r29_ready", n_rdy - r0, 1);
    chk("r29_error", n_err - e0, 0);
    chk("r29_code", scan_code, 8'h29);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
